// File: rtl/dly_chain_monitor.sv
// Ring-oscillator edge counter over a programmable CLK window.
// Optional MIN_CNT/FAIL threshold check under DLY_MON_THRESH_EN.
module dly_chain_monitor #(
    parameter int CNT_W       = 12,
    parameter int WIN_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN,
    input  logic             I,
`ifdef DLY_MON_THRESH_EN
    input  logic [CNT_W-1:0] MIN_CNT,
    output logic             FAIL,
`endif
    output logic [CNT_W-1:0] CNT,
    output logic             DONE,
    output logic             BUSY,
    output logic             OVF
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] MAX_M1 = MAX - 1'b1;
    localparam logic [WIN_W-1:0] FL_END = WIN_W'(SYNC_STAGES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_i_d;
    logic [1:0]             r_state;
    logic [WIN_W-1:0]       r_win;
    logic [WIN_W-1:0]       r_tmr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;
    logic                   w_i_s;
    logic                   w_rise;

    assign w_i_s  = r_sync[SYNC_STAGES-1];
    assign w_rise = w_i_s & ~r_i_d;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_sync <= '0;
            r_i_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], I};
            r_i_d  <= w_i_s;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_tmr   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            CNT     <= '0;
            OVF     <= 1'b0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_FLUSH;
                        r_win   <= WIN;
                        r_tmr   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Edges are ignored here while i_d settles behind i_s.
                    if (r_tmr == FL_END) begin
                        r_tmr   <= '0;
                        r_state <= (r_win != '0) ? S_COUNT : S_DONE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_COUNT: begin
                    if (w_rise) begin
                        if (r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
                        if (r_cnt >= MAX_M1) r_ovf <= 1'b1;
                    end
                    if (r_tmr == r_win - 1'b1) r_state <= S_DONE;
                    else r_tmr <= r_tmr + 1'b1;
                end
                S_DONE: begin
                    CNT     <= r_cnt;
                    OVF     <= r_ovf;
                    DONE    <= 1'b1;
                    BUSY    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DLY_MON_THRESH_EN
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) FAIL <= 1'b0;
        else if (r_state == S_DONE) FAIL <= (r_cnt < MIN_CNT) | r_ovf;
    end
`endif

endmodule

// File: tb/tb_dly_chain_monitor.sv
// Bench for dly_chain_monitor: 12-bit and 4-bit counters share stimulus.
// Threshold ports are exercised when DLY_MON_THRESH_EN is defined.
module tb_dly_chain_monitor;

    typedef struct {
        int win; int per; int lvl;
        int cnt; int ovf; int cnt4; int ovf4;
        int min; int fail;
    } vec_t;

    typedef struct {
        int cnt; int ovf; int cnt4; int ovf4;
        int fail; int cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RN;
    logic        START;
    logic [9:0]  WIN;
    logic        I = 1'b0;
    logic [11:0] CNT;
    logic        DONE, BUSY, OVF;
    logic [3:0]  CNT4;
    logic        DONE4, BUSY4, OVF4;
    logic [11:0] MIN_CNT;
    logic        FAIL, FAIL4;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ndone = 0;
    int   per = 4;
    int   lvl = 0;
    int   ph = 0;
    exp_t sb[$];
    vec_t tbl[9];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    dly_chain_monitor #(.CNT_W(12), .WIN_W(10), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RN(RN), .START(START), .WIN(WIN), .I(I),
`ifdef DLY_MON_THRESH_EN
        .MIN_CNT(MIN_CNT), .FAIL(FAIL),
`endif
        .CNT(CNT), .DONE(DONE), .BUSY(BUSY), .OVF(OVF)
    );

    dly_chain_monitor #(.CNT_W(4), .WIN_W(10), .SYNC_STAGES(2)) dut4 (
        .CLK(CLK), .RN(RN), .START(START), .WIN(WIN), .I(I),
`ifdef DLY_MON_THRESH_EN
        .MIN_CNT(MIN_CNT[3:0]), .FAIL(FAIL4),
`endif
        .CNT(CNT4), .DONE(DONE4), .BUSY(BUSY4), .OVF(OVF4)
    );

`ifndef DLY_MON_THRESH_EN
    assign FAIL  = 1'b0;
    assign FAIL4 = 1'b0;
`endif

    // Phase-locked oscillator model: per==0 holds I at lvl.
    always @(negedge CLK) begin
        if (per == 0) begin
            I = (lvl != 0);
        end else begin
            ph = (ph + 1) % per;
            I = (ph < per / 2);
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RN === 1'b1 && DONE === 1'b1) begin
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: DONE=1 with no pending run at cycle %0d",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("cnt", int'(CNT), e.cnt);
                chk("ovf", int'(OVF), e.ovf);
                chk("busy_at_done", int'(BUSY), 0);
                chk("done4", int'(DONE4), 1);
                chk("cnt4", int'(CNT4), e.cnt4);
                chk("ovf4", int'(OVF4), e.ovf4);
`ifdef DLY_MON_THRESH_EN
                chk("fail", int'(FAIL), e.fail);
`endif
            end
        end
    end

    task automatic wait_idle(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d runs pending after %0d cycles",
                     sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic launch(vec_t v);
        exp_t e;
        per = v.per;
        lvl = v.lvl;
        repeat (4) @(negedge CLK);
        WIN     = 10'(v.win);
        MIN_CNT = 12'(v.min);
        START   = 1'b1;
        e.cnt  = v.cnt;
        e.ovf  = v.ovf;
        e.cnt4 = v.cnt4;
        e.ovf4 = v.ovf4;
        e.fail = v.fail;
        e.cyc  = cyc + v.win + 4;
        sb.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        chk("busy_rise", int'(BUSY), 1);
    endtask

    task automatic run(vec_t v);
        launch(v);
        wait_idle(v.win + 20);
    endtask

    initial begin
        vec_t v;
        int   nd0;
        tbl = '{
            '{100, 4, 0, 25,  0, 15, 1, 30,  1},
            '{100, 4, 0, 25,  0, 15, 1, 25,  0},
            '{50,  0, 1, 0,   0, 0,  0, 0,   0},
            '{64,  2, 0, 32,  0, 15, 1, 0,   0},
            '{8,   2, 0, 4,   0, 4,  0, 0,   0},
            '{0,   4, 0, 0,   0, 0,  0, 0,   0},
            '{30,  3, 0, 10,  0, 10, 0, 10,  0},
            '{1000, 2, 0, 500, 0, 15, 1, 501, 1},
            '{20,  0, 0, 0,   0, 0,  0, 0,   0}
        };
        RN      = 1'b0;
        START   = 1'b0;
        WIN     = '0;
        MIN_CNT = '0;
        repeat (3) @(negedge CLK);
        chk("rst_cnt", int'(CNT), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_ovf", int'(OVF), 0);
        RN = 1'b1;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 9; i++) run(tbl[i]);

        // Nonzero result first, so the async clear is observable.
        v = '{40, 2, 0, 20, 0, 15, 1, 0, 0};
        run(v);
        per     = 4;
        WIN     = 10'd100;
        START   = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (30) @(negedge CLK);
        RN = 1'b0;
        #1;
        chk("midrst_cnt", int'(CNT), 0);
        chk("midrst_done", int'(DONE), 0);
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_ovf", int'(OVF), 0);
        chk("midrst_cnt4", int'(CNT4), 0);
        repeat (2) @(negedge CLK);
        RN = 1'b1;
        v = '{10, 2, 0, 5, 0, 5, 0, 0, 0};
        run(v);

        // START pulses while busy must not queue a second run.
        nd0 = ndone;
        v = '{20, 4, 0, 5, 0, 5, 0, 0, 0};
        launch(v);
        repeat (5) @(negedge CLK);
        WIN   = 10'd3;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_idle(60);
        repeat (40) @(negedge CLK);
        chk("single_done", ndone, nd0 + 1);
        chk("idle_busy", int'(BUSY), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
